// File: rtl/imm_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : imm_decode_stage
// Purpose  : Registered immediate decoder at the IF/ID boundary. Accepts
//            instructions over valid/ready, decodes the immediate format and
//            presents a sign-extended XLEN immediate from a main entry backed
//            by a skid entry.
// Revision : 1.0  initial release
// ============================================================================
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [TAG_W-1:0] out_tag,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt
);

    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_imm32  = 7'b0011011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_system = 7'b1110011;

    localparam logic [2:0] c_fmt_none = 3'd0;
    localparam logic [2:0] c_fmt_i    = 3'd1;
    localparam logic [2:0] c_fmt_s    = 3'd2;
    localparam logic [2:0] c_fmt_b    = 3'd3;
    localparam logic [2:0] c_fmt_u    = 3'd4;
    localparam logic [2:0] c_fmt_j    = 3'd5;
    localparam logic [2:0] c_fmt_z    = 3'd6;

    localparam bit c_rv64 = (XLEN == 64);

    // Decoded values for the incoming instruction (decode sits before the flops)
    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;

    // Entry storage
    logic             r_main_valid;
    logic [31:0]      r_main_instr;
    logic [TAG_W-1:0] r_main_tag;
    logic [XLEN-1:0]  r_main_imm;
    logic [2:0]       r_main_fmt;

    logic             r_skid_valid;
    logic [31:0]      r_skid_instr;
    logic [TAG_W-1:0] r_skid_tag;
    logic [XLEN-1:0]  r_skid_imm;
    logic [2:0]       r_skid_fmt;

    logic             w_in_xfer;
    logic             w_main_free;

    // Immediate decode of the fetched instruction into a 32-bit value whose
    // bit 31 is the extension bit (zero for the CSR uimm form).
    always_comb begin
        w_imm32 = 32'd0;
        w_fmt   = c_fmt_none;
        case (in_instr[6:0])
            c_op_imm, c_op_load, c_op_jalr: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_fmt   = c_fmt_i;
            end
            c_op_imm32: begin
                if (c_rv64) begin
                    w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                    w_fmt   = c_fmt_i;
                end
            end
            c_op_store: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_fmt   = c_fmt_s;
            end
            c_op_branch: begin
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                w_fmt   = c_fmt_b;
            end
            c_op_lui, c_op_auipc: begin
                w_imm32 = {in_instr[31:12], 12'd0};
                w_fmt   = c_fmt_u;
            end
            c_op_jal: begin
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
                w_fmt   = c_fmt_j;
            end
            c_op_system: begin
                if (in_instr[14]) begin
                    w_imm32 = {27'd0, in_instr[19:15]};
                    w_fmt   = c_fmt_z;
                end
            end
            default: begin
                w_imm32 = 32'd0;
                w_fmt   = c_fmt_none;
            end
        endcase
    end

    // Widen to XLEN by replicating bit 31 of the 32-bit immediate
    generate
        if (XLEN == 64) begin : g_xlen64
            assign w_imm = {{32{w_imm32[31]}}, w_imm32};
        end else begin : g_xlen32
            assign w_imm = w_imm32;
        end
    endgenerate

    // in_ready comes straight from the skid flop: no path from out_ready
    assign in_ready    = !r_skid_valid;
    assign w_in_xfer   = in_valid && !r_skid_valid;
    assign w_main_free = !r_main_valid || out_ready;

    // Main/skid entry update; flush beats any concurrent transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_instr <= '0;
            r_main_tag   <= '0;
            r_main_imm   <= '0;
            r_main_fmt   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_skid_tag   <= '0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= '0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // Main is empty or draining: refill from skid first, else from input.
            // in_ready is low whenever skid holds data, so both cannot arrive at once.
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_instr <= r_skid_instr;
                r_main_tag   <= r_skid_tag;
                r_main_imm   <= r_skid_imm;
                r_main_fmt   <= r_skid_fmt;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_main_valid <= 1'b1;
                r_main_instr <= in_instr;
                r_main_tag   <= in_tag;
                r_main_imm   <= w_imm;
                r_main_fmt   <= w_fmt;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            // Main is stalled: park the new instruction in skid
            r_skid_valid <= 1'b1;
            r_skid_instr <= in_instr;
            r_skid_tag   <= in_tag;
            r_skid_imm   <= w_imm;
            r_skid_fmt   <= w_fmt;
        end
    end

    assign out_valid = r_main_valid;
    assign out_instr = r_main_instr;
    assign out_tag   = r_main_tag;
    assign out_imm   = r_main_imm;
    assign out_fmt   = r_main_fmt;

endmodule
`default_nettype wire
